// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: merges Icache/Dcache miss traffic onto one AXI3 master.
// One read and one write outstanding at a time; responses routed to the owner.
module cache_axi_arbiter #(
    parameter logic [3:0] ICACHE_ID = 4'd0,
    parameter logic [3:0] DCACHE_ID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] i_araddr,
    input  logic [3:0]  i_arlen,
    input  logic        i_arvalid,
    output logic        i_arready,
    output logic [31:0] i_rdata,
    output logic        i_rvalid,
    output logic        i_rlast,

    input  logic [31:0] d_araddr,
    input  logic [3:0]  d_arlen,
    input  logic        d_arvalid,
    output logic        d_arready,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    output logic        d_rlast,

    input  logic [31:0] d_awaddr,
    input  logic [3:0]  d_awlen,
    input  logic        d_awvalid,
    output logic        d_awready,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    input  logic        d_wvalid,
    input  logic        d_wlast,
    output logic        d_wready,
    output logic        d_bvalid,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    input  logic        rlast,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    output logic        wlast,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } rstate_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } wstate_t;

    rstate_t rstate;
    wstate_t wstate;
    logic    gnt_d;
    logic    req_v;

    // arvalid of whichever master currently holds the read grant
    assign req_v = gnt_d ? d_arvalid : i_arvalid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rstate <= R_IDLE;
            gnt_d  <= 1'b0;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    if (d_arvalid || i_arvalid) begin
                        gnt_d  <= d_arvalid;
                        rstate <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (req_v && arready) begin
                        rstate <= R_DATA;
                    end else if (!req_v) begin
                        rstate <= R_IDLE;
                    end
                end
                R_DATA: begin
                    if (rvalid && rlast) begin
                        rstate <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wstate <= W_IDLE;
        end else begin
            unique case (wstate)
                W_IDLE: begin
                    if (d_awvalid) begin
                        wstate <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (d_awvalid && awready) begin
                        wstate <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (d_wvalid && wready && d_wlast) begin
                        wstate <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bvalid) begin
                        wstate <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Fixed fields are only driven while a read is in flight, so idle is all-zero
    always_comb begin
        arid      = 4'd0;
        araddr    = 32'd0;
        arlen     = 4'd0;
        arsize    = 3'd0;
        arburst   = 2'd0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        i_arready = 1'b0;
        d_arready = 1'b0;
        i_rdata   = 32'd0;
        d_rdata   = 32'd0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        i_rlast   = 1'b0;
        d_rlast   = 1'b0;
        if (rstate != R_IDLE) begin
            arid    = gnt_d ? DCACHE_ID : ICACHE_ID;
            arsize  = 3'b010;
            arburst = 2'b01;
        end
        if (rstate == R_ADDR) begin
            arvalid   = req_v;
            araddr    = gnt_d ? d_araddr : i_araddr;
            arlen     = gnt_d ? d_arlen : i_arlen;
            i_arready = !gnt_d && arready;
            d_arready = gnt_d && arready;
        end
        if (rstate == R_DATA) begin
            rready   = 1'b1;
            i_rdata  = rdata;
            d_rdata  = rdata;
            i_rvalid = !gnt_d && rvalid;
            d_rvalid = gnt_d && rvalid;
            i_rlast  = !gnt_d && rlast;
            d_rlast  = gnt_d && rlast;
        end
    end

    always_comb begin
        awid      = 4'd0;
        wid       = 4'd0;
        awaddr    = 32'd0;
        awlen     = 4'd0;
        awsize    = 3'd0;
        awburst   = 2'd0;
        awvalid   = 1'b0;
        d_awready = 1'b0;
        wdata     = 32'd0;
        wstrb     = 4'd0;
        wvalid    = 1'b0;
        wlast     = 1'b0;
        d_wready  = 1'b0;
        bready    = 1'b0;
        d_bvalid  = 1'b0;
        if (wstate != W_IDLE) begin
            awid    = DCACHE_ID;
            wid     = DCACHE_ID;
            awsize  = 3'b010;
            awburst = 2'b01;
        end
        if (wstate == W_ADDR) begin
            awvalid   = d_awvalid;
            awaddr    = d_awaddr;
            awlen     = d_awlen;
            d_awready = awready;
        end
        if (wstate == W_DATA) begin
            wvalid   = d_wvalid;
            wdata    = d_wdata;
            wstrb    = d_wstrb;
            wlast    = d_wlast;
            d_wready = wready;
        end
        if (wstate == W_RESP) begin
            bready   = 1'b1;
            d_bvalid = bvalid;
        end
    end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Bench for cache_axi_arbiter: bench-side cache masters, AXI slave and a
// transaction-level model of grant/phase ownership checked every cycle.
module tb_cache_axi_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] i_araddr = '0, d_araddr = '0;
    logic [3:0]  i_arlen = '0, d_arlen = '0;
    logic        i_arvalid = 1'b0, d_arvalid = 1'b0;
    logic        i_arready, d_arready;
    logic [31:0] i_rdata, d_rdata;
    logic        i_rvalid, d_rvalid, i_rlast, d_rlast;
    logic [31:0] d_awaddr = '0, d_wdata = '0;
    logic [3:0]  d_awlen = '0, d_wstrb = '0;
    logic        d_awvalid = 1'b0, d_wvalid = 1'b0, d_wlast = 1'b0;
    logic        d_awready, d_wready, d_bvalid;
    logic [3:0]  arid, awid, wid, arlen, awlen, wstrb;
    logic [31:0] araddr, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, awvalid, wvalid, wlast, rready, bready;
    logic        arready = 1'b0, awready = 1'b0, wready = 1'b0;
    logic        rvalid = 1'b0, rlast = 1'b0, bvalid = 1'b0;
    logic [31:0] rdata = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit ar_always = 1'b1;
    logic [35:0] wq[$];

    cache_axi_arbiter dut (
        .clk(clk), .reset(reset),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid),
        .i_arready(i_arready), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
        .i_rlast(i_rlast),
        .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arvalid(d_arvalid),
        .d_arready(d_arready), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
        .d_rlast(d_rlast),
        .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awvalid(d_awvalid),
        .d_awready(d_awready), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_wvalid(d_wvalid), .d_wlast(d_wlast), .d_wready(d_wready),
        .d_bvalid(d_bvalid),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
        .wlast(wlast), .wready(wready), .bvalid(bvalid), .bready(bready)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rpat(logic [31:0] a, int k);
        return a ^ (32'(k) * 32'h9E37_79B9) ^ 32'h0000_5A5A;
    endfunction

    function automatic logic [31:0] wpat(logic [31:0] a, int k);
        return a + 32'(k) * 32'h0101_0103;
    endfunction

    function automatic logic [3:0] spat(logic [31:0] a, int k);
        return 4'(a[5:2]) + 4'(k);
    endfunction

    // AXI read slave: one burst at a time, data derived from address and beat
    initial begin : s_rd
        bit busy;
        logic [31:0] sa;
        logic [3:0] sl;
        int sb;
        busy = 0; sa = '0; sl = '0; sb = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy = 0;
            end else if (!busy && arvalid && arready) begin
                busy = 1; sa = araddr; sl = arlen; sb = 0;
            end else if (busy && rvalid && rready) begin
                if (sb == int'(sl)) busy = 0;
                sb++;
            end
            @(posedge clk);
            #1;
            arready = !busy && (ar_always || $urandom_range(0, 2) != 0);
            rvalid = busy && (ar_always || $urandom_range(0, 3) != 0);
            rdata = rpat(sa, sb);
            rlast = busy && (sb == int'(sl));
        end
    end

    // AXI write slave: checks AW against issue order, W beats against pattern
    initial begin : s_wr
        bit busy, resp, wtog;
        logic [31:0] sa;
        logic [3:0] sl;
        logic [35:0] e;
        int sb, bd;
        busy = 0; resp = 0; wtog = 0; sa = '0; sl = '0; sb = 0; bd = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy = 0; resp = 0;
            end else if (!busy && !resp && awvalid && awready) begin
                if (wq.size() == 0) begin
                    chk("aw_unexpected", 256'(awaddr), 256'(0));
                    e = {awaddr, awlen};
                end else begin
                    e = wq.pop_front();
                end
                chk("aw_fields", 256'({awid, awaddr, awlen, awsize, awburst}),
                    256'({4'd1, e, 3'b010, 2'b01}));
                busy = 1; sa = awaddr; sl = awlen; sb = 0;
            end else if (busy && wvalid && wready) begin
                chk("w_beat", 256'({wid, wdata, wstrb, wlast}),
                    256'({4'd1, wpat(sa, sb), spat(sa, sb), sb == int'(sl)}));
                if (wlast) begin
                    busy = 0; resp = 1;
                    bd = ar_always ? 0 : $urandom_range(0, 3);
                end
                sb++;
            end else if (resp && bvalid && bready) begin
                resp = 0;
            end else if (resp && bd > 0) begin
                bd--;
            end
            @(posedge clk);
            #1;
            wtog = !wtog;
            awready = !busy && !resp && (ar_always || $urandom_range(0, 1) != 0);
            wready = busy && wtog;
            bvalid = resp && bd == 0;
        end
    end

    // Ownership model: who holds the read channel and which write phase is open
    initial begin : model
        int rown;
        bit rsent, ov, ea_i, ea_d, dp, ri, rd;
        int wph;
        logic [31:0] oa;
        logic [3:0] ol;
        rown = 0; rsent = 0; wph = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("reset_outputs", 256'({i_arready, d_arready, i_rdata,
                    d_rdata, i_rvalid, d_rvalid, i_rlast, d_rlast, d_awready,
                    d_wready, d_bvalid, arid, awid, wid, araddr, awaddr, arlen,
                    awlen, arsize, awsize, arburst, awburst, arvalid, awvalid,
                    wvalid, wlast, wdata, wstrb, rready, bready}), 256'(0));
                rown = 0; rsent = 0; wph = 0;
            end else begin
                ea_i = rown == 1 && !rsent;
                ea_d = rown == 2 && !rsent;
                dp = rown != 0 && rsent;
                ov = ea_i ? i_arvalid : (ea_d ? d_arvalid : 1'b0);
                oa = (rown == 2) ? d_araddr : i_araddr;
                ol = (rown == 2) ? d_arlen : i_arlen;
                chk("arvalid", 256'(arvalid), 256'(ov));
                chk("ar_ready_route", 256'({i_arready, d_arready}),
                    256'({ea_i && arready, ea_d && arready}));
                if (ov)
                    chk("ar_fields", 256'({arid, araddr, arlen, arsize, arburst}),
                        256'({ea_d ? 4'd1 : 4'd0, oa, ol, 3'b010, 2'b01}));
                ri = dp && rown == 1;
                rd = dp && rown == 2;
                chk("rready", 256'(rready), 256'(dp));
                chk("r_route", 256'({i_rvalid, i_rlast, d_rvalid, d_rlast}),
                    256'({ri && rvalid, ri && rlast, rd && rvalid, rd && rlast}));
                chk("aw_route", 256'({awvalid, d_awready}),
                    256'({wph == 1 && d_awvalid, wph == 1 && awready}));
                if (wph == 1 && d_awvalid)
                    chk("aw_pass", 256'({awid, awaddr, awlen, awsize, awburst}),
                        256'({4'd1, d_awaddr, d_awlen, 3'b010, 2'b01}));
                chk("w_route", 256'({wvalid, d_wready}),
                    256'({wph == 2 && d_wvalid, wph == 2 && wready}));
                if (wph == 2 && d_wvalid)
                    chk("w_pass", 256'({wid, wdata, wstrb, wlast}),
                        256'({4'd1, d_wdata, d_wstrb, d_wlast}));
                chk("b_route", 256'({bready, d_bvalid}),
                    256'({wph == 3, wph == 3 && bvalid}));
                if (rown == 0) begin
                    rsent = 0;
                    if (d_arvalid) rown = 2;
                    else if (i_arvalid) rown = 1;
                end else if (!rsent) begin
                    if (ov && arready) rsent = 1;
                    else if (!ov) rown = 0;
                end else if (rvalid && rlast) begin
                    rown = 0; rsent = 0;
                end
                case (wph)
                    0: if (d_awvalid) wph = 1;
                    1: if (d_awvalid && awready) wph = 2;
                    2: if (d_wvalid && wready && d_wlast) wph = 3;
                    3: if (bvalid) wph = 0;
                    default: wph = 0;
                endcase
            end
        end
    end

    // Cache-side read: m=1 Dcache, m=0 Icache; checks every received beat
    task automatic rd(input bit m, input logic [31:0] a, input logic [3:0] l,
                      output int rq, output int arc, output int lc,
                      output int nb);
        bit got, done;
        int t;
        @(posedge clk);
        #1;
        if (m) begin
            d_araddr = a; d_arlen = l; d_arvalid = 1;
        end else begin
            i_araddr = a; i_arlen = l; i_arvalid = 1;
        end
        rq = cyc; arc = -1; lc = -1; nb = 0;
        got = 0; t = 0;
        while (!got && t < 400) begin
            @(negedge clk);
            t++;
            got = m ? d_arready : i_arready;
        end
        if (!got) chk("ar_timeout", 256'(0), 256'(1));
        arc = cyc;
        @(posedge clk);
        #1;
        if (m) d_arvalid = 0;
        else i_arvalid = 0;
        done = 0; t = 0;
        while (got && !done && t < 400) begin
            @(negedge clk);
            t++;
            if (m ? d_rvalid : i_rvalid) begin
                chk("rdata", 256'(m ? d_rdata : i_rdata), 256'(rpat(a, nb)));
                if (m ? d_rlast : i_rlast) begin
                    chk("rlast_pos", 256'(nb), 256'(l));
                    done = 1; lc = cyc;
                end
                nb++;
            end
        end
        if (got && !done) chk("r_timeout", 256'(0), 256'(1));
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] l);
        bit got;
        int t, nb, post;
        @(posedge clk);
        #1;
        wq.push_back({a, l});
        d_awaddr = a; d_awlen = l; d_awvalid = 1;
        got = 0; t = 0;
        while (!got && t < 400) begin
            @(negedge clk);
            t++;
            got = d_awready;
        end
        if (!got) chk("aw_timeout", 256'(0), 256'(1));
        @(posedge clk);
        #1;
        d_awvalid = 0;
        for (int k = 0; k <= int'(l); k++) begin
            d_wvalid = 1; d_wdata = wpat(a, k);
            d_wstrb = spat(a, k); d_wlast = (k == int'(l));
            got = 0; t = 0;
            while (!got && t < 400) begin
                @(negedge clk);
                t++;
                got = d_wready;
            end
            if (!got) chk("w_timeout", 256'(k), 256'(0));
            @(posedge clk);
            #1;
        end
        d_wvalid = 0; d_wlast = 0;
        nb = 0; t = 0; post = 0;
        while (t < 400 && post < 4) begin
            @(negedge clk);
            t++;
            if (d_bvalid) nb++;
            if (nb > 0) post++;
        end
        chk("bvalid_pulses", 256'(nb), 256'(1));
    endtask

    initial begin : main
        int q0, a0, l0, n0, q1, a1, l1, n1, n;
        bit got;
        #1 reset = 1;
        #1;
        chk("reset_async_init", 256'({arvalid, awvalid, rready, bready,
            arsize, awburst}), 256'(0));
        repeat (3) @(posedge clk);
        #1 reset = 0;

        rd(0, 32'h1FC0_0040, 4'd15, q0, a0, l0, n0);
        chk("i_ar_latency", 256'(a0 - q0), 256'(1));
        chk("i_beats", 256'(n0), 256'(16));

        fork
            rd(1, 32'h0000_1200, 4'd15, q1, a1, l1, n1);
            rd(0, 32'h1FC0_0080, 4'd15, q0, a0, l0, n0);
        join
        chk("d_first", 256'(a1 < a0), 256'(1));
        chk("i_after_d_gap", 256'(a0 - l1), 256'(2));
        chk("both_beats", 256'({n1[7:0], n0[7:0]}), 256'({8'd16, 8'd16}));

        rd(1, 32'hBFAF_0004, 4'd0, q1, a1, l1, n1);
        chk("uncached_beats", 256'(n1), 256'(1));
        chk("uncached_last", 256'(l1 - a1), 256'(1));

        wr(32'h0000_2000, 4'd15);

        fork
            rd(0, 32'h1FC0_0100, 4'd15, q0, a0, l0, n0);
            wr(32'h0000_3040, 4'd15);
        join
        chk("overlap_i_beats", 256'(n0), 256'(16));

        @(posedge clk);
        #1;
        i_araddr = 32'h1FC0_0200; i_arlen = 4'd15; i_arvalid = 1;
        got = 0; n = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            got = i_arready;
        end
        chk("rst_ar_seen", 256'(got), 256'(1));
        @(posedge clk);
        #1;
        i_arvalid = 0;
        n = 0;
        for (int t = 0; t < 100 && n < 7; t++) begin
            @(negedge clk);
            if (i_rvalid) n++;
        end
        chk("rst_beats_seen", 256'(n), 256'(7));
        @(posedge clk);
        #1 reset = 1;
        #1;
        chk("rst_async_mid", 256'({arvalid, rready, i_rvalid}), 256'(0));
        repeat (2) @(posedge clk);
        #1 reset = 0;
        rd(0, 32'h1FC0_0300, 4'd15, q0, a0, l0, n0);
        chk("post_rst_beats", 256'(n0), 256'(16));
        chk("post_rst_latency", 256'(a0 - q0), 256'(1));

        ar_always = 0;
        for (int it = 0; it < 30; it++) begin
            fork
                begin
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    rd(0, 32'h1FC0_0000 + ($urandom() & 32'h0000_FFC0),
                       ($urandom_range(0, 1) != 0) ? 4'd15 : 4'($urandom_range(0, 15)),
                       q0, a0, l0, n0);
                end
                begin
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    rd(1, $urandom() & 32'hFFFF_FFC0,
                       ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                       q1, a1, l1, n1);
                end
                begin
                    repeat ($urandom_range(0, 6)) @(posedge clk);
                    wr($urandom() & 32'hFFFF_FFC0, 4'($urandom_range(0, 15)));
                end
            join
        end
        repeat (4) @(posedge clk);
        chk("wq_drained", 256'(wq.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_axi_arbiter.md
Name: cache_axi_arbiter

Overview:
Sits directly downstream of the Dcache and Icache miss engines and merges their request channels onto the single AXI3 master port of the CPU. It carries Icache burst reads, Dcache line refills, Dcache uncached single-beat reads, Dcache writebacks and Dcache uncached writes. It arbitrates one outstanding read and one outstanding write at a time and routes responses back to the owner. All cache-side handshakes keep the Dcache's existing pulse semantics: ready/last/bvalid are seen only while the request is owned.

Parameters:
ICACHE_ID, 4'd0, AXI ID driven for Icache reads
DCACHE_ID, 4'd1, AXI ID driven for all Dcache reads and writes

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high
i_araddr, d_araddr  in  32  cache read burst start address
i_arlen, d_arlen  in  4  beats minus one (15 = line refill, 0 = uncached)
i_arvalid, d_arvalid  in  1  read request, held until matching arready
i_arready, d_arready  out  1  read address accepted (pulse)
i_rdata, d_rdata  out  32  read beat data, broadcast from rdata
i_rvalid, d_rvalid  out  1  read beat valid, owner only
i_rlast, d_rlast  out  1  last read beat, owner only
d_awaddr  in  32  write burst address
d_awlen  in  4  write beats minus one
d_awvalid  in  1  write address request
d_awready  out  1  write address accepted (pulse)
d_wdata  in  32  write beat data
d_wstrb  in  4  byte strobes
d_wvalid, d_wlast  in  1  write beat valid / last beat
d_wready  out  1  write beat accepted
d_bvalid  out  1  write response (pulse)
arid, awid, wid  out  4  AXI IDs
araddr, awaddr  out  32  AXI addresses
arlen, awlen  out  4  AXI burst lengths
arsize, awsize  out  3  fixed 3'b010
arburst, awburst  out  2  fixed 2'b01 (INCR)
arvalid, awvalid, wvalid, wlast  out  1  AXI valids / last
arready, awready, wready, rvalid, rlast, bvalid  in  1  AXI slave handshakes
rdata  in  32  AXI read data
wdata  out  32  AXI write data
wstrb  out  4  AXI strobes
rready, bready  out  1  AXI response ready
rid, rresp, bid, bresp: not ported; the top level leaves them unconnected and the block ignores them.

Behaviour:
- Reset (asynchronous assert): read FSM to R_IDLE, write FSM to W_IDLE, grant register cleared. Every output is 0 immediately, including the fixed fields when idle. This also applies mid-burst; any pending AXI transaction is abandoned.
- Read FSM R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - R_IDLE: if d_arvalid, latch grant = D (Dcache has fixed priority). Else if i_arvalid, grant = I. Move to R_ADDR next edge. This gives a 1-cycle arbitration latency.
  - R_ADDR: arvalid/araddr/arlen pass combinationally from the granted master; arid = granted ID. The granted *_arready = arready. On arvalid&&arready go to R_DATA.
  - R_DATA: rready = 1. The granted *_rvalid = rvalid and *_rlast = rlast; the other master sees 0. On rvalid&&rlast go to R_IDLE. Re-arbitration happens the following cycle, so the minimum gap between bursts is 1 idle cycle.
  - If the granted master drops arvalid in R_ADDR before the handshake, return to R_IDLE without issuing.
- Write FSM W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: on d_awvalid go to W_ADDR.
  - W_ADDR: awvalid/awaddr/awlen pass through from the Dcache; awid = wid = DCACHE_ID. d_awready = awready. On awvalid&&awready go to W_DATA.
  - W_DATA: wvalid/wdata/wstrb/wlast pass through; d_wready = wready. On wvalid&&wready&&wlast go to W_RESP.
  - W_RESP: bready = 1, d_bvalid = bvalid. On bvalid go to W_IDLE.
  - Outside W_DATA, wvalid = 0 and d_wready = 0.
- Read and write FSMs are independent. An Icache read may overlap a Dcache writeback; read-after-write ordering for Dcache is guaranteed by the Dcache itself, which waits for bvalid.
- Simultaneous i_arvalid and d_arvalid in R_IDLE: Dcache wins; the Icache is served after the Dcache burst completes. No starvation, because the Dcache stalls the pipeline.
- Beats are not counted. Burst length is trusted from the master; termination is on rlast/wlast only.

Test Plan:
- Icache alone, i_arlen=15, addr 0x1FC0_0040: arid=0, araddr passed through; 16 beats on i_rvalid; i_rlast with beat 16; d_rvalid stays 0.
- i_arvalid and d_arvalid raised the same cycle: d burst issued first with arid=1; i_arready stays 0 until 1 cycle after d_rlast, then the Icache burst is issued.
- Dcache uncached read, d_arlen=0: single beat with d_rvalid=d_rlast=1; returns to R_IDLE; arvalid low on the next cycle.
- Dcache writeback, awlen=15, wready toggled every other cycle: 16 beats forwarded in order; d_bvalid pulses exactly once, on the cycle bvalid is asserted in W_RESP.
- Icache burst in progress while a Dcache write occurs: both complete; rvalid stays routed to the Icache only; the AW/W/B sequence is unaffected.
- reset asserted mid-read at beat 7: arvalid, rready and i_rvalid go 0 without waiting for a clock edge; after release, a new request is issued normally.
